// File: rtl/lsu_pkg.sv
// Shared encodings, state enum and request payload for the load/store unit.
package lsu_pkg;

    localparam int unsigned XLEN              = 32;
    localparam int unsigned DEFAULT_MEM_WORDS = 41;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int unsigned FLT_MISALIGN = 0;
    localparam int unsigned FLT_RANGE    = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_RESP
    } lsu_state_e;

    // Request fields captured at accept and used for the rest of the transaction.
    typedef struct packed {
        logic            we;
        logic [1:0]      size;
        logic            zero_ext;
        logic [1:0]      offset;
        logic [XLEN-1:0] wdata;
        logic [4:0]      rd;
    } lsu_req_t;

    // Size 11 is never a legal access, so it reports as misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return offset[0];
            SZ_WORD: return offset != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane extract/extend for loads and lane merge for sub-word stores.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      offset,
    input  logic [1:0]      size,
    input  logic            zero_ext,
    input  logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] load_value,
    output logic [XLEN-1:0] store_word
);

    logic [4:0]  byte_shamt;
    logic [4:0]  half_shamt;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_shamt = {offset, 3'b000};
        half_shamt = {offset[1], 4'b0000};
        byte_lane  = 8'(word >> byte_shamt);
        half_lane  = 16'(word >> half_shamt);
        load_value = word;
        store_word = store_data;
        case (size)
            SZ_BYTE: begin
                load_value = zero_ext ? XLEN'(byte_lane)
                                      : {{(XLEN-8){byte_lane[7]}}, byte_lane};
                store_word = (word & ~(32'h0000_00FF << byte_shamt))
                           | (XLEN'(store_data[7:0]) << byte_shamt);
            end
            SZ_HALF: begin
                load_value = zero_ext ? XLEN'(half_lane)
                                      : {{(XLEN-16){half_lane[15]}}, half_lane};
                store_word = (word & ~(32'h0000_FFFF << half_shamt))
                           | (XLEN'(store_data[15:0]) << half_shamt);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: byte/half/word access to a word-addressed memory,
// with read-modify-write for sub-word stores and extended, tagged load results.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = DEFAULT_MEM_WORDS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [4:0]      req_rd,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic [4:0]      resp_rd,
    output logic [1:0]      resp_fault,
    output logic [XLEN-1:0] mem_address,
    output logic [XLEN-1:0] mem_write_data,
    output logic            mem_write_signal,
    input  logic [XLEN-1:0] mem_read_data
);

    lsu_state_e      state;
    lsu_req_t        req_q;
    logic [1:0]      fault_c;
    logic [XLEN-1:0] load_value;
    logic [XLEN-1:0] store_word;

    assign req_ready        = (state == ST_IDLE) && !reset;
    assign mem_write_signal = (state == ST_WRITE) && !reset;

    // Fault classification of the incoming request, used only on the accept edge.
    always_comb begin
        fault_c               = '0;
        fault_c[FLT_MISALIGN] = is_misaligned(req_size, req_addr[1:0]);
        fault_c[FLT_RANGE]    = XLEN'(req_addr[XLEN-1:2]) >= MEM_WORDS;
    end

    lsu_lane_align u_lane_align (
        .word       (mem_read_data),
        .offset     (req_q.offset),
        .size       (req_q.size),
        .zero_ext   (req_q.zero_ext),
        .store_data (req_q.wdata),
        .load_value (load_value),
        .store_word (store_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            req_q          <= '0;
            resp_valid     <= 1'b0;
            resp_data      <= '0;
            resp_rd        <= '0;
            resp_fault     <= '0;
            mem_address    <= '0;
            mem_write_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_q.we       <= req_we;
                        req_q.size     <= req_size;
                        req_q.zero_ext <= req_unsigned;
                        req_q.offset   <= req_addr[1:0];
                        req_q.wdata    <= req_wdata;
                        req_q.rd       <= req_rd;
                        if (fault_c != 2'b00) begin
                            // Faulting requests never touch memory.
                            resp_valid <= 1'b1;
                            resp_fault <= fault_c;
                            resp_data  <= '0;
                            resp_rd    <= '0;
                            state      <= ST_RESP;
                        end else begin
                            mem_address <= XLEN'(req_addr[XLEN-1:2]);
                            if (req_we && (req_size == SZ_WORD)) begin
                                mem_write_data <= req_wdata;
                                state          <= ST_WRITE;
                            end else begin
                                state <= ST_READ;
                            end
                        end
                    end
                end
                ST_READ: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (req_q.we) begin
                        mem_write_data <= store_word;
                        state          <= ST_WRITE;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_data  <= load_value;
                        resp_rd    <= req_q.rd;
                        resp_fault <= '0;
                        state      <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    resp_valid <= 1'b1;
                    resp_data  <= '0;
                    resp_rd    <= '0;
                    resp_fault <= '0;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: behavioural memory plus transaction-level reference model.
module tb_load_store_unit;

    localparam int unsigned NW = 41;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic [1:0]  resp_fault;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_signal;
    logic [31:0] mem_read_data;

    logic [31:0] mem     [0:NW-1];
    logic [31:0] ref_mem [0:NW-1];
    int          wr_count;
    logic [31:0] wr_addr;
    int          n_checks;
    int          n_errors;

    load_store_unit #(.MEM_WORDS(NW)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_we           (req_we),
        .req_size         (req_size),
        .req_unsigned     (req_unsigned),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .req_rd           (req_rd),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_data        (resp_data),
        .resp_rd          (resp_rd),
        .resp_fault       (resp_fault),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_signal (mem_write_signal),
        .mem_read_data    (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-addressed memory with a registered read port.
    always @(posedge clk) begin
        if (mem_write_signal) begin
            wr_count <= wr_count + 1;
            wr_addr  <= mem_address;
            if (mem_address < NW) mem[6'(mem_address)] <= mem_write_data;
        end
        mem_read_data <= (mem_address < NW) ? mem[6'(mem_address)] : 32'h0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One full transaction: model the expected result, drive, check, then release with backpressure.
    task automatic do_txn(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd, input int hold, output logic [31:0] got);
        logic [1:0]  ef;
        logic [31:0] ed;
        logic [4:0]  erd;
        logic [31:0] w;
        logic [31:0] s_data;
        logic [4:0]  s_rd;
        logic [1:0]  s_flt;
        int          elat, ewr, idx, sh, lat, wr0;

        ef[0] = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
        ef[1] = (addr >> 2) >= 32'(NW);
        ed = 32'h0; erd = 5'd0; ewr = 0; idx = 0; elat = 1;
        if (ef == 2'b00) begin
            idx = int'(addr >> 2);
            w   = ref_mem[idx];
            sh  = 8 * int'(addr[1:0]);
            if (!we) begin
                elat = 3;
                erd  = rd;
                case (size)
                    2'd0: begin
                        ed = (w >> sh) & 32'hFF;
                        if (!uns && ed >= 32'h80) ed = ed | 32'hFFFF_FF00;
                    end
                    2'd1: begin
                        ed = (w >> sh) & 32'hFFFF;
                        if (!uns && ed >= 32'h8000) ed = ed | 32'hFFFF_0000;
                    end
                    default: ed = w;
                endcase
            end else begin
                ewr = 1;
                case (size)
                    2'd0: begin
                        ref_mem[idx] = (w & ~(32'hFF << sh)) | ((wdata & 32'hFF) << sh);
                        elat = 4;
                    end
                    2'd1: begin
                        ref_mem[idx] = (w & ~(32'hFFFF << sh)) | ((wdata & 32'hFFFF) << sh);
                        elat = 4;
                    end
                    default: begin
                        ref_mem[idx] = wdata;
                        elat = 2;
                    end
                endcase
            end
        end

        check("req_ready_pre", 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_rd       = rd;
        wr0          = wr_count;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(elat));
        check("resp_fault", 32'(resp_fault), 32'(ef));
        check("resp_data", resp_data, ed);
        check("resp_rd", 32'(resp_rd), 32'(erd));
        check("write_pulses", 32'(wr_count - wr0), 32'(ewr));
        if (ewr != 0) begin
            check("write_addr", wr_addr, addr >> 2);
            check("mem_word", mem[idx], ref_mem[idx]);
        end
        got    = resp_data;
        s_data = resp_data;
        s_rd   = resp_rd;
        s_flt  = resp_fault;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_data", resp_data, s_data);
            check("hold_rd_flt", {25'd0, s_flt != resp_fault, resp_rd}, {27'd0, s_rd});
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("post_valid", 32'(resp_valid), 32'd0);
        check("post_req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        int          wr0;
        n_checks     = 0;
        n_errors     = 0;
        wr_count     = 0;
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        req_rd       = 5'd0;
        resp_ready   = 1'b0;
        for (int i = 0; i < int'(NW); i++) ref_mem[i] = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_resp_rd_flt", {25'd0, resp_fault, resp_rd}, 32'd0);
        check("rst_mem_addr", mem_address, 32'd0);
        check("rst_mem_wdata", mem_write_data, 32'd0);
        check("rst_mem_we", 32'(mem_write_signal), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        #1;

        // Preload every word so later loads see known contents.
        for (int i = 0; i < int'(NW); i++)
            do_txn(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, 5'd0, 0, d);

        do_txn(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 5'd0, 0, d);
        do_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd7, 0, d);
        check("dir_word_load", d, 32'hDEAD_BEEF);
        do_txn(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF_7F01, 5'd0, 0, d);
        do_txn(1'b0, 2'd0, 1'b0, 32'h12, 32'h0, 5'd3, 0, d);
        check("dir_byte_s", d, 32'hFFFF_FFFF);
        do_txn(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 5'd4, 0, d);
        check("dir_byte_u", d, 32'h0000_0080);
        do_txn(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 5'd5, 0, d);
        check("dir_half_s", d, 32'h0000_7F01);
        do_txn(1'b1, 2'd0, 1'b0, 32'h11, 32'h1234_56AA, 5'd9, 0, d);
        check("dir_rmw_word", mem[4], 32'h80FF_AA01);
        do_txn(1'b0, 2'd1, 1'b0, 32'h13, 32'h0, 5'd6, 0, d);
        do_txn(1'b0, 2'd2, 1'b0, 32'hA4, 32'h0, 5'd6, 0, d);
        do_txn(1'b0, 2'd1, 1'b0, 32'hA5, 32'h0, 5'd6, 0, d);
        do_txn(1'b1, 2'd3, 1'b0, 32'h20, 32'h5555_5555, 5'd6, 0, d);
        do_txn(1'b0, 2'd2, 1'b0, 32'h9C, 32'h0, 5'd31, 5, d);

        // Reset during WAIT of a sub-word store drops it without a write or response.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h11; req_wdata = 32'h0000_0033; req_rd = 5'd1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        wr0   = wr_count;
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_resp", {resp_data[31:7] | 25'(resp_rd) | 25'(resp_fault), resp_data[6:0]}, 32'd0);
        check("mid_rst_mem_addr", mem_address, 32'd0);
        check("mid_rst_mem_wdata", mem_write_data, 32'd0);
        check("mid_rst_mem_we", 32'(mem_write_signal), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("mid_rst_idle", 32'(req_ready), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("mid_rst_no_resp", 32'(resp_valid), 32'd0);
        check("mid_rst_no_write", 32'(wr_count - wr0), 32'd0);
        check("mid_rst_mem_kept", mem[4], ref_mem[4]);

        // Randomized mix: mostly in-range addresses with occasional wild ones.
        for (int n = 0; n < 200; n++) begin
            logic [31:0] a;
            a = {24'd0, 6'($urandom_range(0, NW + 3)), 2'($urandom)};
            if ($urandom_range(0, 15) == 0) a = $urandom;
            do_txn(1'($urandom), ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                   1'($urandom), a, $urandom, 5'($urandom), $urandom_range(0, 2), d);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
